// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: two-requester round-robin front end for an AES core.
// Holds one job in flight from grant to response handshake, with a WAIT timeout.
module aes_job_scheduler #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_mode,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_mode,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] key,
    output logic              core_start,
    output logic              core_mode,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] job_data_q, job_data_d;
    logic [DATA_W-1:0] job_key_q, job_key_d;
    logic              job_mode_q, job_mode_d;
    logic              job_id_q, job_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic gnt_any;
    logic gnt_id;

    // Arbitration: a lone requester wins, contention goes to the rr pointer.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = (req0_valid & req1_valid) ? rr_q : req1_valid;
    end

    // Next-state logic, job capture, timeout counting and strobes.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        job_data_d = job_data_q;
        job_key_d  = job_key_q;
        job_mode_d = job_mode_q;
        job_id_d   = job_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        core_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = ~rst & gnt_any & ~gnt_id;
                req1_ready = ~rst & gnt_any & gnt_id;
                if (gnt_any) begin
                    job_data_d = gnt_id ? req1_data : req0_data;
                    job_mode_d = gnt_id ? req1_mode : req0_mode;
                    job_key_d  = key;
                    job_id_d   = gnt_id;
                    rr_d       = ~gnt_id;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q != TMAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (core_done) begin
                    rsp_data_d = core_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q >= TLAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and job registers; reset drops any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            job_data_q <= '0;
            job_key_q  <= '0;
            job_mode_q <= 1'b0;
            job_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            job_data_q <= job_data_d;
            job_key_q  <= job_key_d;
            job_mode_q <= job_mode_d;
            job_id_q   <= job_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Operands and response fields come straight from the job registers.
    always_comb begin
        core_mode = job_mode_q;
        core_data = job_data_q;
        core_key  = job_key_q;
        rsp_valid = (state_q == RESP);
        rsp_id    = job_id_q;
        rsp_err   = rsp_err_q;
        rsp_data  = rsp_data_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler: instance A uses the default
// timeout, instance B uses TIMEOUT=8 for the timeout corner cases.
module tb_aes_job_scheduler;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic m0 = 1'b0, m1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0, key = '0;

    logic [1:0] va = 2'b00, ra, vb = 2'b00, rb;
    logic cs_a, cm_a, cd_a = 1'b0, mdn_a = 1'b0;
    logic rv_a, rr_a = 1'b1, rid_a, rerr_a, busy_a;
    logic [W-1:0] cdat_a, ckey_a, cres_a = '0, rdat_a;
    logic cs_b, cm_b, cd_b = 1'b0, mdn_b = 1'b0;
    logic rv_b, rr_b = 1'b1, rid_b, rerr_b, busy_b;
    logic [W-1:0] cdat_b, ckey_b, cres_b = '0, rdat_b;

    aes_job_scheduler #(.DATA_W(W)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(va[0]), .req0_mode(m0), .req0_data(d0), .req0_ready(ra[0]),
        .req1_valid(va[1]), .req1_mode(m1), .req1_data(d1), .req1_ready(ra[1]),
        .key(key), .core_start(cs_a), .core_mode(cm_a), .core_data(cdat_a),
        .core_key(ckey_a), .core_done(cd_a | mdn_a), .core_result(cres_a),
        .rsp_valid(rv_a), .rsp_ready(rr_a), .rsp_id(rid_a), .rsp_err(rerr_a),
        .rsp_data(rdat_a), .busy(busy_a)
    );

    aes_job_scheduler #(.DATA_W(W), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(vb[0]), .req0_mode(m0), .req0_data(d0), .req0_ready(rb[0]),
        .req1_valid(vb[1]), .req1_mode(m1), .req1_data(d1), .req1_ready(rb[1]),
        .key(key), .core_start(cs_b), .core_mode(cm_b), .core_data(cdat_b),
        .core_key(ckey_b), .core_done(cd_b | mdn_b), .core_result(cres_b),
        .rsp_valid(rv_b), .rsp_ready(rr_b), .rsp_id(rid_b), .rsp_err(rerr_b),
        .rsp_data(rdat_b), .busy(busy_b)
    );

    typedef struct {
        int id;
        bit err;
        logic [W-1:0] data;
        int t;
    } rsp_t;

    typedef struct {
        bit mode;
        logic [W-1:0] data;
        logic [W-1:0] key;
    } iss_t;

    rsp_t qa[$], qb[$];
    iss_t ia[$], ib[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string n, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic fail(input string n);
        checks++;
        $display("FAIL %s: event missing or unexpected", n);
    endtask

    // Response monitors: pop one expectation per response and
    // keep comparing while the response is held.
    rsp_t cur_a, cur_b;
    bit have_a = 0, have_b = 0;

    always @(negedge clk) begin
        if (rv_a) begin
            if (!have_a) begin
                if (qa.size() == 0) fail("unexpected_rsp_a");
                else begin
                    cur_a = qa.pop_front();
                    have_a = 1;
                    chk("rsp_lat_a", W'(cyc), W'(cur_a.t));
                end
            end
            if (have_a) begin
                chk("rsp_id_a", W'(rid_a), W'(cur_a.id));
                chk("rsp_err_a", W'(rerr_a), W'(cur_a.err));
                chk("rsp_data_a", rdat_a, cur_a.data);
            end
        end else have_a = 0;
    end

    always @(negedge clk) begin
        if (rv_b) begin
            if (!have_b) begin
                if (qb.size() == 0) fail("unexpected_rsp_b");
                else begin
                    cur_b = qb.pop_front();
                    have_b = 1;
                    chk("rsp_lat_b", W'(cyc), W'(cur_b.t));
                end
            end
            if (have_b) begin
                chk("rsp_id_b", W'(rid_b), W'(cur_b.id));
                chk("rsp_err_b", W'(rerr_b), W'(cur_b.err));
                chk("rsp_data_b", rdat_b, cur_b.data);
            end
        end else have_b = 0;
    end

    // Core models: check operands on start, answer after dly cycles
    // (dly 0 means the core never answers).
    int dly_a = 1, pend_a = 0, dly_b = 1, pend_b = 0;
    bit fix_a = 0;
    logic [W-1:0] fixres_a = '0;
    iss_t ea, eb;

    always @(negedge clk) begin
        cd_a = 1'b0;
        if (pend_a > 0) begin
            pend_a--;
            if (pend_a == 0) cd_a = 1'b1;
        end
        if (cs_a) begin
            if (ia.size() == 0) fail("unexpected_start_a");
            else begin
                ea = ia.pop_front();
                chk("core_mode_a", W'(cm_a), W'(ea.mode));
                chk("core_data_a", cdat_a, ea.data);
                chk("core_key_a", ckey_a, ea.key);
                cres_a = fix_a ? fixres_a : (ea.data ^ ea.key);
            end
            pend_a = dly_a;
        end
    end

    always @(negedge clk) begin
        cd_b = 1'b0;
        if (pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) cd_b = 1'b1;
        end
        if (cs_b) begin
            if (ib.size() == 0) fail("unexpected_start_b");
            else begin
                eb = ib.pop_front();
                chk("core_mode_b", W'(cm_b), W'(eb.mode));
                chk("core_data_b", cdat_b, eb.data);
                chk("core_key_b", ckey_b, eb.key);
                cres_b = eb.data ^ eb.key;
            end
            pend_b = dly_b;
        end
    end

    // Called at a negedge with valids already driven; returns at the
    // negedge after acceptance.
    task automatic accept(input bit inst, input int id, input int lat,
                          input bit err, input logic [W-1:0] rdata,
                          input bit exp_rsp);
        logic [1:0] r;
        logic [1:0] er;
        iss_t e;
        rsp_t s;
        r = 2'b00;
        for (int n = 0; n < 40; n++) begin
            #1;
            r = inst ? rb : ra;
            if (r != 2'b00) break;
            @(negedge clk);
        end
        if (r == 2'b00) begin
            fail("accept_timeout");
            return;
        end
        er = (id == 1) ? 2'b10 : 2'b01;
        chk("grant", W'(r), W'(er));
        e.mode = (id == 1) ? m1 : m0;
        e.data = (id == 1) ? d1 : d0;
        e.key = key;
        s.id = id;
        s.err = err;
        s.data = rdata;
        s.t = cyc + lat;
        if (inst) ib.push_back(e);
        else ia.push_back(e);
        if (exp_rsp) begin
            if (inst) qb.push_back(s);
            else qa.push_back(s);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit inst);
        bit b;
        b = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            b = inst ? busy_b : busy_a;
            if (!b) break;
        end
        if (b) fail("idle_timeout");
    endtask

    task automatic chk_reset_a(input string n);
        chk({n, "_busy"}, W'(busy_a), '0);
        chk({n, "_rv"}, W'(rv_a), '0);
        chk({n, "_cs"}, W'(cs_a), '0);
        chk({n, "_cm"}, W'(cm_a), '0);
        chk({n, "_cdat"}, cdat_a, '0);
        chk({n, "_ckey"}, ckey_a, '0);
        chk({n, "_rid"}, W'(rid_a), '0);
        chk({n, "_rerr"}, W'(rerr_a), '0);
        chk({n, "_rdat"}, rdat_a, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_a("rst");
        chk("rst_busy_b", W'(busy_b), '0);
        rst = 1'b0;
        @(negedge clk);

        // Single job with a known AES-128 vector, done 12 cycles after start.
        d0 = 128'h00112233445566778899aabbccddeeff;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        m0 = 1'b0;
        fix_a = 1;
        fixres_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        dly_a = 12;
        va = 2'b01;
        accept(0, 0, 14, 0, fixres_a, 1);
        va = 2'b00;
        wait_idle(0);
        fix_a = 0;

        // Reset in WAIT, then a late core_done after release.
        dly_a = 0;
        d1 = 128'hdeadbeef_00000000_cafef00d_12345678;
        m1 = 1'b1;
        va = 2'b10;
        accept(0, 1, 0, 0, '0, 0);
        va = 2'b00;
        repeat (3) @(negedge clk);
        chk("wait_busy", W'(busy_a), W'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_reset_a("rstw");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mdn_a = 1'b1;
        @(negedge clk);
        mdn_a = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_a("late");

        // Contention with both valids held: grants alternate from 0.
        dly_a = 3;
        d0 = 128'h11111111_11111111_11111111_11111111;
        d1 = 128'h22222222_22222222_22222222_22222222;
        m0 = 1'b0;
        m1 = 1'b1;
        va = 2'b11;
        for (int j = 0; j < 4; j++) begin
            accept(0, j % 2, 5, 0, ((j % 2) ? d1 : d0) ^ key, 1);
            if (j == 3) va = 2'b00;
            wait_idle(0);
        end

        // Backpressure: response held five cycles with requests pending.
        dly_a = 1;
        rr_a = 1'b0;
        d0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        va = 2'b01;
        accept(0, 0, 3, 0, d0 ^ key, 1);
        va = 2'b11;
        for (int n = 0; n < 20; n++) begin
            if (rv_a) break;
            @(negedge clk);
        end
        if (!rv_a) fail("bp_rsp_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", W'(ra), '0);
            chk("bp_start", W'(cs_a), '0);
            @(negedge clk);
        end
        rr_a = 1'b1;
        va = 2'b00;
        @(negedge clk);
        chk("bp_idle", W'(busy_a), '0);
        chk("bp_rv", W'(rv_a), '0);

        // Timeout on B: core never answers.
        dly_b = 0;
        vb = 2'b01;
        accept(1, 0, 10, 1, '0, 1);
        vb = 2'b00;
        wait_idle(1);

        // Done in the same cycle the counter hits TIMEOUT: done wins.
        dly_b = 8;
        vb = 2'b10;
        accept(1, 1, 10, 0, d1 ^ key, 1);
        vb = 2'b00;
        wait_idle(1);

        // Spurious core_done while idle, then a normal job.
        mdn_b = 1'b1;
        @(negedge clk);
        mdn_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_busy", W'(busy_b), '0);
        chk("spur_rv", W'(rv_b), '0);
        dly_b = 2;
        vb = 2'b01;
        accept(1, 0, 4, 0, d0 ^ key, 1);
        vb = 2'b00;
        wait_idle(1);

        repeat (5) @(negedge clk);
        chk("drain_qa", W'(qa.size()), '0);
        chk("drain_qb", W'(qb.size()), '0);
        chk("drain_ia", W'(ia.size()), '0);
        chk("drain_ib", W'(ib.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
